// File: rtl/usb_turn_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usb_turn_ctrl : full-speed proxy bus-turnaround controller (wire ownership)|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module usb_turn_ctrl #(
   parameter int TMO_CYCLES = 72,
   parameter int EOP_HOLD   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       h_k,
   input  logic       h_se0,
   input  logic       d_k,
   input  logic       d_se0,
   input  logic       pid_valid,
   input  logic [7:0] pid,
   output logic       fwd_h2d,
   output logic       fwd_d2h,
   output logic [2:0] state,
   output logic       txn_done,
   output logic       tmo_err
);

   localparam int TMO_W  = $clog2(TMO_CYCLES + 1);
   localparam int HOLD_W = $clog2(EOP_HOLD + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(EOP_HOLD - 1);

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SOF   = 4'b0101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;
   localparam logic [3:0] PID_NYET  = 4'b0110;

   typedef enum logic [2:0] {
      IDLE_H  = 3'd0,
      H2D     = 3'd1,
      H2D_EOP = 3'd2,
      WAIT_D  = 3'd3,
      D2H     = 3'd4,
      D2H_EOP = 3'd5
   } state_t;

   state_t              cur;
   state_t              nxt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [HOLD_W-1:0]   hold_nxt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [TMO_W-1:0]    tmo_nxt;
   logic [7:0]          last_pid;
   logic [7:0]          last_pid_nxt;
   logic                pid_got;
   logic                pid_got_nxt;
   logic                done_nxt;
   logic                err_nxt;
   logic                pid_ok;
   logic [3:0]          code;

   // A PID counts only if one was latched and its check nibble is consistent.
   assign pid_ok = pid_got && (last_pid[7:4] == ~last_pid[3:0]);
   assign code   = last_pid[3:0];
   assign state  = cur;

   function automatic logic needs_response(input logic [3:0] c);
      return (c == PID_IN) || (c == PID_DATA0) || (c == PID_DATA1);
   endfunction

   function automatic logic host_completes(input logic [3:0] c);
      return (c == PID_SOF) || (c == PID_ACK) || (c == PID_NAK) || (c == PID_STALL);
   endfunction

   function automatic logic dev_completes(input logic [3:0] c);
      return (c == PID_ACK) || (c == PID_NAK) || (c == PID_STALL) || (c == PID_NYET);
   endfunction

   always_comb begin
      nxt          = cur;
      hold_nxt     = hold_cnt;
      tmo_nxt      = tmo_cnt;
      last_pid_nxt = last_pid;
      pid_got_nxt  = pid_got;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;

      case (cur)
         IDLE_H: begin
            if (h_k) begin
               nxt          = H2D;
               last_pid_nxt = 8'd0;
               pid_got_nxt  = 1'b0;
            end
         end

         H2D: begin
            hold_nxt = '0;
            if (pid_valid && !pid_got) begin
               last_pid_nxt = pid;
               pid_got_nxt  = 1'b1;
            end
            if (h_se0) begin
               nxt = H2D_EOP;
            end
         end

         H2D_EOP: begin
            // SE0 reappearing during the trailing-J hold restarts the count.
            if (h_se0) begin
               hold_nxt = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               hold_nxt = '0;
               if (pid_ok && needs_response(code)) begin
                  nxt     = WAIT_D;
                  tmo_nxt = '0;
               end else begin
                  nxt      = IDLE_H;
                  done_nxt = pid_ok && host_completes(code);
               end
            end else begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end

         WAIT_D: begin
            // Device SOP has priority over a host retry in the same cycle.
            if (d_k) begin
               nxt          = D2H;
               last_pid_nxt = 8'd0;
               pid_got_nxt  = 1'b0;
            end else if (h_k) begin
               nxt          = H2D;
               err_nxt      = 1'b1;
               last_pid_nxt = 8'd0;
               pid_got_nxt  = 1'b0;
            end else if (tmo_cnt == TMO_LAST) begin
               nxt     = IDLE_H;
               err_nxt = 1'b1;
            end else begin
               tmo_nxt = tmo_cnt + TMO_W'(1);
            end
         end

         D2H: begin
            hold_nxt = '0;
            if (pid_valid && !pid_got) begin
               last_pid_nxt = pid;
               pid_got_nxt  = 1'b1;
            end
            if (d_se0) begin
               nxt = D2H_EOP;
            end
         end

         D2H_EOP: begin
            if (d_se0) begin
               hold_nxt = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               hold_nxt = '0;
               nxt      = IDLE_H;
               done_nxt = pid_ok && dev_completes(code);
            end else begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end

         default: begin
            nxt = IDLE_H;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur      <= IDLE_H;
         hold_cnt <= '0;
         tmo_cnt  <= '0;
         last_pid <= 8'd0;
         pid_got  <= 1'b0;
         fwd_h2d  <= 1'b0;
         fwd_d2h  <= 1'b0;
         txn_done <= 1'b0;
         tmo_err  <= 1'b0;
      end else begin
         cur      <= nxt;
         hold_cnt <= hold_nxt;
         tmo_cnt  <= tmo_nxt;
         last_pid <= last_pid_nxt;
         pid_got  <= pid_got_nxt;
         // Forwards follow the next state so they switch on the same edge as it.
         fwd_h2d  <= (nxt == H2D) || (nxt == H2D_EOP);
         fwd_d2h  <= (nxt == D2H) || (nxt == D2H_EOP);
         txn_done <= done_nxt;
         tmo_err  <= err_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_usb_turn_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_usb_turn_ctrl : directed and randomized transaction bench               |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_usb_turn_ctrl;

   localparam int TMO  = 72;
   localparam int HOLD = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       h_k;
   logic       h_se0;
   logic       d_k;
   logic       d_se0;
   logic       pid_valid;
   logic [7:0] pid;
   logic       fwd_h2d;
   logic       fwd_d2h;
   logic [2:0] state;
   logic       txn_done;
   logic       tmo_err;

   int checks   = 0;
   int failures = 0;

   logic [7:0] host_tbl [9] = '{8'h69, 8'hC3, 8'h4B, 8'hA5, 8'hD2, 8'h5A, 8'h1E, 8'hE1, 8'h2D};
   logic [7:0] dev_tbl  [7] = '{8'hD2, 8'h5A, 8'h1E, 8'h96, 8'h4B, 8'hC3, 8'h69};
   logic [7:0] hp;
   logic [7:0] dp;
   bit         sp;
   int         mode;

   usb_turn_ctrl #(.TMO_CYCLES(TMO), .EOP_HOLD(HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .h_k       (h_k),
      .h_se0     (h_se0),
      .d_k       (d_k),
      .d_se0     (d_se0),
      .pid_valid (pid_valid),
      .pid       (pid),
      .fwd_h2d   (fwd_h2d),
      .fwd_d2h   (fwd_d2h),
      .state     (state),
      .txn_done  (txn_done),
      .tmo_err   (tmo_err)
   );

   always #5 clk = ~clk;

   // Transaction-level reference: outcomes follow directly from the PID tables.
   function automatic bit pid_consistent(input logic [7:0] p);
      return p[7:4] == ~p[3:0];
   endfunction

   function automatic bit host_to_wait(input logic [7:0] p, input bit sent);
      logic [3:0] c;
      c = p[3:0];
      return sent && pid_consistent(p) && (c == 4'h9 || c == 4'h3 || c == 4'hB);
   endfunction

   function automatic bit host_done(input logic [7:0] p, input bit sent);
      logic [3:0] c;
      c = p[3:0];
      return sent && pid_consistent(p) && (c == 4'h5 || c == 4'h2 || c == 4'hA || c == 4'hE);
   endfunction

   function automatic bit dev_done(input logic [7:0] p);
      logic [3:0] c;
      c = p[3:0];
      return pid_consistent(p) && (c == 4'h2 || c == 4'hA || c == 4'hE || c == 4'h6);
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic hk, input logic hse0, input logic dk, input logic dse0);
      h_k       = hk;
      h_se0     = hse0;
      d_k       = dk;
      d_se0     = dse0;
      pid_valid = 1'b0;
   endtask

   task automatic step(input string tag, input logic [2:0] es, input logic eh,
                       input logic ed, input logic edone, input logic etmo);
      @(posedge clk);
      #1;
      chk({tag, ".state"},    {5'd0, state},    {5'd0, es});
      chk({tag, ".fwd_h2d"},  {7'd0, fwd_h2d},  {7'd0, eh});
      chk({tag, ".fwd_d2h"},  {7'd0, fwd_d2h},  {7'd0, ed});
      chk({tag, ".txn_done"}, {7'd0, txn_done}, {7'd0, edone});
      chk({tag, ".tmo_err"},  {7'd0, tmo_err},  {7'd0, etmo});
      chk({tag, ".excl"},     {7'd0, fwd_h2d & fwd_d2h}, 8'd0);
   endtask

   task automatic idle(input int n, input bit noise);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, noise ? rb() : 1'b0, noise, noise ? rb() : 1'b0);
         if (noise) begin
            pid_valid = rb();
            pid       = 8'($urandom);
         end
         step("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic wait_idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         step("wait_d", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic host_pkt(input logic [7:0] p, input bit sent, input int len,
                           input bit glitch, input bit from_wait);
      bit w;
      bit dn;
      w  = host_to_wait(p, sent);
      dn = host_done(p, sent);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step("h_sop", 3'd1, 1'b1, 1'b0, 1'b0, from_wait);
      for (int i = 0; i < len; i++) begin
         drive(rb(), 1'b0, rb(), 1'b0);
         if (sent && i == 0) begin
            pid_valid = 1'b1;
            pid       = p;
         end else if (sent && i == len - 1) begin
            pid_valid = 1'b1;
            pid       = (p == 8'hE1) ? 8'h69 : 8'hE1;
         end
         step("h_body", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      step("h_se0a", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      pid_valid = 1'b1;
      pid       = 8'h69;
      step("h_se0b", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      if (glitch) begin
         for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            step("h_glitch", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
         end
         drive(1'b0, 1'b1, 1'b0, 1'b0);
         step("h_rese0", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      for (int j = 1; j <= HOLD; j++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         if (j < HOLD) step("h_hold", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
         else          step("h_end", w ? 3'd3 : 3'd0, 1'b0, 1'b0, dn, 1'b0);
      end
   endtask

   task automatic dev_pkt(input logic [7:0] p, input int len, input bit collide);
      drive(collide, 1'b0, 1'b1, 1'b0);
      step("d_sop", 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < len; i++) begin
         drive(rb(), 1'b0, rb(), 1'b0);
         if (i == 0) begin
            pid_valid = 1'b1;
            pid       = p;
         end else if (i == len - 1) begin
            pid_valid = 1'b1;
            pid       = (p == 8'hD2) ? 8'h4B : 8'hD2;
         end
         step("d_body", 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      step("d_se0a", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      step("d_se0b", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int j = 1; j <= HOLD; j++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         if (j < HOLD) step("d_hold", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
         else          step("d_end", 3'd0, 1'b0, 1'b0, dev_done(p), 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1;
      pid = 8'd0;
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      step("reset0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("reset1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      idle(2, 1'b0);

      // IN / DATA1 / ACK
      host_pkt(8'h69, 1'b1, 3, 1'b0, 1'b0);
      wait_idle(20);
      dev_pkt(8'h4B, 4, 1'b0);
      idle(3, 1'b0);
      host_pkt(8'hD2, 1'b1, 2, 1'b0, 1'b0);
      idle(2, 1'b0);

      // OUT / DATA0 / device ACK
      host_pkt(8'hE1, 1'b1, 3, 1'b0, 1'b0);
      idle(2, 1'b0);
      host_pkt(8'hC3, 1'b1, 5, 1'b1, 1'b0);
      wait_idle(6);
      dev_pkt(8'hD2, 2, 1'b0);
      idle(2, 1'b0);

      // IN timeout
      host_pkt(8'h69, 1'b1, 3, 1'b0, 1'b0);
      wait_idle(TMO - 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      step("timeout", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b0);

      // SOF, then unsolicited device K and bus noise while idle
      host_pkt(8'hA5, 1'b1, 2, 1'b0, 1'b0);
      idle(8, 1'b1);
      idle(1, 1'b0);

      // d_k and h_k together at the terminal count
      host_pkt(8'h69, 1'b1, 2, 1'b0, 1'b0);
      wait_idle(TMO - 1);
      dev_pkt(8'h5A, 2, 1'b1);
      idle(2, 1'b0);

      // Reset in the middle of a device packet
      host_pkt(8'h69, 1'b1, 3, 1'b0, 1'b0);
      wait_idle(5);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      step("rd_sop", 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      pid_valid = 1'b1;
      pid       = 8'hD2;
      step("rd_body", 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      step("rd_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      idle(2, 1'b0);
      host_pkt(8'h69, 1'b1, 4, 1'b1, 1'b0);
      wait_idle(3);
      dev_pkt(8'h4B, 3, 1'b0);
      idle(1, 1'b0);
      host_pkt(8'hD2, 1'b1, 2, 1'b0, 1'b0);
      idle(1, 1'b0);

      // Missing PID: no outcome pulse
      host_pkt(8'h69, 1'b0, 3, 1'b0, 1'b0);
      idle(1, 1'b0);

      // Randomized transactions
      for (int t = 0; t < 16; t++) begin
         hp = host_tbl[$urandom_range(0, 8)];
         if ($urandom_range(0, 5) == 0) hp = hp ^ 8'h10;
         sp = ($urandom_range(0, 7) != 0);
         host_pkt(hp, sp, $urandom_range(2, 6), rb(), 1'b0);
         if (host_to_wait(hp, sp)) begin
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
               dp = dev_tbl[$urandom_range(0, 6)];
               if ($urandom_range(0, 5) == 0) dp = dp ^ 8'h01;
               wait_idle($urandom_range(0, TMO - 1));
               dev_pkt(dp, $urandom_range(2, 5), 1'b0);
            end else if (mode == 1) begin
               wait_idle(TMO - 1);
               drive(1'b0, 1'b0, 1'b0, 1'b0);
               step("r_timeout", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
               wait_idle($urandom_range(0, TMO - 2));
               host_pkt(8'hD2, 1'b1, $urandom_range(2, 4), 1'b0, 1'b1);
            end
         end
         idle($urandom_range(1, 4), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/usb_turn_ctrl.md
# usb_turn_ctrl

Bus-turnaround controller for the USB full-speed proxy. It decides which side of the proxy currently owns the wire, and enables exactly one repeater direction at a time: host→device or device→host. Its inputs are synchronized line-state flags from both ports and PIDs from the packet decoder. It tracks each transaction phase: token, data and handshake. It opens the device→host path only when a device response is legal, and closes it on EOP or on response timeout.

## Interface
Parameters:
- TMO_CYCLES, 72, clk cycles allowed in WAIT_D for device SOP (18 bit times at 4 clk/bit)
- EOP_HOLD, 8, clk cycles the active driver stays enabled after SE0 ends (trailing J)

Ports:
- clk  in  1  clock, 4× full-speed bit rate
- rst  in  1  reset, synchronous, active-high
- h_k  in  1  host port in K state (synchronized)
- h_se0  in  1  host port SE0 (synchronized)
- d_k  in  1  device port in K state (synchronized)
- d_se0  in  1  device port SE0 (synchronized)
- pid_valid  in  1  one-cycle pulse, pid holds a decoded PID byte
- pid  in  8  PID byte, [3:0] code, [7:4] check (must equal ~[3:0])
- fwd_h2d  out  1  enable host→device repeater
- fwd_d2h  out  1  enable device→host repeater
- state  out  3  current FSM state
- txn_done  out  1  one-cycle pulse, transaction completed with handshake or SOF
- tmo_err  out  1  one-cycle pulse, expected device response missing

## Operation
- States and encoding: IDLE_H=0, H2D=1, H2D_EOP=2, WAIT_D=3, D2H=4, D2H_EOP=5.
- IDLE_H: both forwards off. On h_k, go to H2D. d_k and h_se0 are ignored, so a device gets no unsolicited path and a bus-reset SE0 is ignored.
- H2D: fwd_h2d=1. The first valid pid_valid in the packet is latched as last_pid; later pulses are ignored. On h_se0, go to H2D_EOP.
- H2D_EOP: fwd_h2d=1 while h_se0 is high. After h_se0 falls, count EOP_HOLD cycles, then branch on the latched code:
  - IN (1001), DATA0 (0011), DATA1 (1011): go to WAIT_D.
  - SOF (0101): go to IDLE_H and pulse txn_done.
  - ACK (0010), NAK (1010), STALL (1110): go to IDLE_H and pulse txn_done.
  - OUT (0001), SETUP (1101), invalid check, or no PID latched: go to IDLE_H with no pulse.
- WAIT_D: both forwards off. tmo_cnt starts at 0 on entry and increments each cycle.
  - d_k: go to D2H.
  - tmo_cnt==TMO_CYCLES-1 without d_k: go to IDLE_H and pulse tmo_err.
  - h_k (host retried): go to H2D and pulse tmo_err.
  - d_k and h_k in the same cycle: d_k wins.
- D2H: fwd_d2h=1. Latch the first valid PID. On d_se0, go to D2H_EOP. h_k is ignored.
- D2H_EOP: same hold rule as H2D_EOP, applied to d_se0. Then go to IDLE_H. Pulse txn_done only if the device PID code is ACK, NAK, STALL or NYET (0110). After device DATA, the host's handshake later completes the transaction through the H2D path.
- Invariant: fwd_h2d and fwd_d2h are never both 1.
- last_pid is cleared on entry to H2D and to D2H.
- pid_valid is ignored in every state other than H2D and D2H.

## Timing
- All outputs are registered.
- Reset values: state=0, fwd_h2d=0, fwd_d2h=0, txn_done=0, tmo_err=0. Counters and last_pid are also 0.
- rst in any state, including mid-packet, forces IDLE_H on the next edge, and both forwards drop that edge.
- fwd_h2d rises on the edge after h_k is sampled in IDLE_H. fwd_d2h rises on the edge after d_k is sampled in WAIT_D.
- EOP hold: if h_se0 falls at edge N, fwd_h2d falls at edge N+EOP_HOLD, together with the state change. The same rule applies to fwd_d2h and d_se0.
- SE0 glitch: SE0 returning high during the hold count restarts the count on its next fall.
- txn_done and tmo_err assert for exactly one cycle, on the same edge as the state change.
- Timeout: with entry to WAIT_D at edge E and no d_k or h_k, tmo_err pulses and state becomes 0 at edge E+TMO_CYCLES.
- tmo_cnt width is clog2(TMO_CYCLES+1). It never wraps, because it is cleared on every WAIT_D entry.

## Test plan
- IN sequence: host IN (pid 0x69), then after 20 cycles device DATA1 (0x4B), then host ACK (0xD2). Required response:
  - state walks 1, 2, 3, 4, 5, 0, 1, 2, 0.
  - fwd_d2h is high only during the device packet.
  - txn_done pulses once, after the ACK hold.
  - tmo_err stays 0.
- OUT sequence: host OUT (0xE1), host DATA0 (0xC3), device ACK (0xD2). Required response:
  - WAIT_D is entered only after DATA0.
  - txn_done pulses at the end of D2H_EOP.
  - fwd outputs are never both high.
- IN timeout: host IN with no device activity. Required response:
  - tmo_err pulses exactly TMO_CYCLES edges after WAIT_D entry.
  - state returns to 0.
  - fwd_d2h stays 0 throughout.
- SOF plus unsolicited device K: host SOF (0xA5), then d_k asserted while in IDLE_H. Required response:
  - txn_done pulses after the SOF hold.
  - d_k is ignored: state stays 0 and fwd_d2h stays 0.
- Collision at terminal count: d_k and h_k together at tmo_cnt==TMO_CYCLES-1. Required response:
  - next state is 4 (D2H).
  - no tmo_err pulse.
- Reset mid-D2H: rst asserted in D2H for one cycle. Required response:
  - fwd_d2h=0, state=0, and both pulses 0 on the next edge.
  - a following host IN is handled normally.
